// File: rtl/shift_add_multiplier_if.sv
// rtl/shift_add_multiplier_if.sv - start/done handshake and operand/product bus for shift_add_multiplier
interface shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    // Requester drives operands and start, collects the product
    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    // Multiplier core side
    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift/add unsigned multiplier (option: SHIFT_ADD_MULT_EARLY_TERM_EN)
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = 2 * WIDTH + 1;
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t               state_q, state_d;
    logic [RW-1:0]        sr_q, sr_d;          // {carry, acc, mq}
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       sum;
    logic [CW-1:0]        count_inc;

    assign sum       = {1'b0, sr_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    assign count_inc = count_q + CW'(1);

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    logic          rest_zero;
    logic [RW-1:0] sr_early;

    // Detect that every multiplier bit still to be consumed is zero
    always_comb begin
        rest_zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i < (WIDTH - int'(count_q))) && sr_q[i]) begin
                rest_zero = 1'b0;
            end
        end
    end

    assign sr_early = sr_q >> (WIDTH_C - count_q);
`endif

    // Next-state, datapath and product capture; product loads on the edge entering DONE
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d    = {1'b0, {WIDTH{1'b0}}, bus.multiplier};
                    mcand_d = bus.multiplicand;
                    count_d = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
                if (rest_zero) begin
                    sr_d      = sr_early;
                    product_d = sr_early[2*WIDTH-1:0];
                    state_d   = DONE;
                end else begin
                    if (sr_q[0]) begin
                        sr_d = {sum, sr_q[WIDTH-1:0]};
                    end
                    state_d = SHIFT;
                end
`else
                if (sr_q[0]) begin
                    sr_d = {sum, sr_q[WIDTH-1:0]};
                end
                state_d = SHIFT;
`endif
            end
            SHIFT: begin
                sr_d    = {1'b0, sr_q[RW-1:1]};
                count_d = count_inc;
                if (count_inc == WIDTH_C) begin
                    product_d = sr_q[2*WIDTH:1];
                    state_d   = DONE;
                end else begin
                    state_d = ADD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier
module tb_shift_add_multiplier;
    localparam int W = 4;

    typedef struct {
        logic [2*W-1:0] prod;
        int             due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   tests;
    int   fails;
    logic prev_done;
    exp_t sb_q[$];

    shift_add_multiplier_if #(.WIDTH(W)) bus ();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        int n;
        n = 0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) n = i + 1;
        end
        return (n == W) ? 2 * W : 2 * n + 1;
`else
        return 2 * W + 0 * int'(b[0]);
`endif
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, output int e0);
        int   k;
        exp_t e;
        k = 0;
        @(negedge clk);
        while (bus.busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("idle_before_start", 64'(bus.busy), 64'd0);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        @(posedge clk);
        #1;
        e0      = cyc;
        e.prod  = (2*W)'(a) * (2*W)'(b);
        e.due   = e0 + exp_lat(b);
        sb_q.push_back(e);
        bus.start        = 1'b0;
        bus.multiplicand = W'($urandom);
        bus.multiplier   = W'($urandom);
        check("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    // Compare every done pulse against the oldest expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_done) begin
                check("busy_after_done", 64'(bus.busy), 64'd0);
                check("done_single", 64'(bus.done), 64'd0);
            end
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("product", 64'(bus.product), 64'(e.prod));
                    check("latency", 64'(cyc), 64'(e.due));
                end
            end
            prev_done = bus.done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        int e1;
        int e2;
        tests            = 0;
        fails            = 0;
        cyc              = 0;
        prev_done        = 1'b0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_product", 64'(bus.product), 64'd0);
        reset = 1'b0;

        start_op(4'd8, 4'd9, e0);
        drain();

        start_op(4'd15, 4'd15, e1);
        start_op(4'd3, 4'd5, e2);
        check("b2b_gap", 64'(e2 - e1), 64'(2 * W + 2));
        drain();

        start_op(4'd0, 4'd11, e0);
        drain();
        start_op(4'd11, 4'd0, e0);
        drain();
        start_op(4'd9, 4'd1, e0);
        drain();
        start_op(4'd9, 4'd8, e0);
        drain();

        start_op(4'd7, 4'd6, e0);
        @(posedge clk);
        @(posedge clk);
        #2;
        bus.start        = 1'b1;
        bus.multiplicand = 4'd1;
        bus.multiplier   = 4'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        start_op(4'd13, 4'd13, e0);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_busy", 64'(bus.busy), 64'd0);
        check("async_rst_done", 64'(bus.done), 64'd0);
        check("async_rst_product", 64'(bus.product), 64'd0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_product", 64'(bus.product), 64'd0);

        start_op(4'd2, 4'd3, e0);
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
